// File: rtl/axis_rx_pkt_fifo_pkg.sv
// Shared AXIS Ethernet types for the RX packet FIFO slice: beat layout and write-FSM states.
package axis_eth_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic                   last;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

  typedef enum logic [1:0] {SYNC, PASS, DROP} wr_state_t;

endpackage

// File: rtl/axis_rx_pkt_fifo_if.sv
// 64-bit AXI-Stream bundle; master drives the beat, slave drives tready.
interface axis_rx_pkt_fifo_if;
  import axis_eth_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic                   tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_rx_pkt_fifo_ram.sv
// Simple dual-port RAM with one write port and a registered (1-cycle) read port.
module axis_sdp_ram #(
  parameter int WIDTH  = 73,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: forwards only whole, good frames; drops bad and overflowing ones.
// Optional saturating frame counters when AXIS_RX_FIFO_STATS_EN is defined.
module axis_rx_pkt_fifo
  import axis_eth_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk156,
  input  logic               rst_n,
  axis_rx_pkt_fifo_if.slave  s_axis,
  axis_rx_pkt_fifo_if.master m_axis,
  output logic               frame_drop
`ifdef AXIS_RX_FIFO_STATS_EN
  ,
  output logic [31:0]        stat_good_frames,
  output logic [31:0]        stat_bad_frames,
  output logic [31:0]        stat_ovf_frames
`endif
);

  localparam int              PTR_W   = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [1:0]      ST_SYNC = SYNC;
  localparam logic [1:0]      ST_PASS = PASS;
  localparam logic [1:0]      ST_DROP = DROP;

  logic [1:0]       wr_state;
  logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic             tready_q;
  logic             full, accept, commit_ev, bad_ev, ovf_ev;
  logic             ram_re, rd_pending, out_valid, pf_valid, pop;
  logic [1:0]       occ;
  axis_beat_t       wr_beat, ram_q, pf_beat, out_beat;

  assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
  assign accept    = (wr_state == ST_PASS) && s_axis.tvalid && !full;
  assign commit_ev = accept && s_axis.tlast && !s_axis.tuser;
  assign bad_ev    = accept && s_axis.tlast && s_axis.tuser;
  assign ovf_ev    = s_axis.tvalid && s_axis.tlast &&
                     (((wr_state == ST_PASS) && full) || (wr_state == ST_DROP));
  assign wr_beat   = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  // wr_ptr runs ahead speculatively; only commit_ptr is visible to the read side.
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      wr_state   <= ST_SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_drop <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      tready_q   <= 1'b1;
      frame_drop <= bad_ev || ovf_ev;
      case (wr_state)
        ST_SYNC: if (!s_axis.tvalid || s_axis.tlast) wr_state <= ST_PASS;
        ST_PASS: if (s_axis.tvalid) begin
          if (!full) begin
            if (s_axis.tlast && s_axis.tuser) wr_ptr <= commit_ptr;
            else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
              if (s_axis.tlast) commit_ptr <= wr_ptr + PTR_W'(1);
            end
          end else begin
            wr_ptr <= commit_ptr;
            if (!s_axis.tlast) wr_state <= ST_DROP;
          end
        end
        ST_DROP: if (s_axis.tvalid && s_axis.tlast) wr_state <= ST_PASS;
        default: wr_state <= ST_SYNC;
      endcase
    end
  end

  axis_sdp_ram #(
    .WIDTH ($bits(axis_beat_t)),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk156),
    .wr_en  (accept),
    .wr_addr(wr_ptr[ADDR_W-1:0]),
    .wr_data(wr_beat),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr[ADDR_W-1:0]),
    .rd_data(ram_q)
  );

  // A read is issued only if out, prefetch and the in-flight RAM word leave room for it.
  assign pop    = out_valid && m_axis.tready;
  assign occ    = 2'(out_valid) + 2'(pf_valid) + 2'(rd_pending) - 2'(pop);
  assign ram_re = (rd_ptr != commit_ptr) && (occ < 2'd2);

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      out_beat   <= '0;
      pf_beat    <= '0;
    end else begin
      rd_pending <= ram_re;
      if (ram_re) rd_ptr <= rd_ptr + PTR_W'(1);
      if (!out_valid || pop) begin
        if (pf_valid) begin
          out_beat  <= pf_beat;
          out_valid <= 1'b1;
          pf_valid  <= rd_pending;
          if (rd_pending) pf_beat <= ram_q;
        end else if (rd_pending) begin
          out_beat  <= ram_q;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pending) begin
        pf_beat  <= ram_q;
        pf_valid <= 1'b1;
      end
    end
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tuser  = 1'b0;

`ifdef AXIS_RX_FIFO_STATS_EN
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      stat_good_frames <= '0;
      stat_bad_frames  <= '0;
      stat_ovf_frames  <= '0;
    end else begin
      if (commit_ev && (stat_good_frames != '1)) stat_good_frames <= stat_good_frames + 32'd1;
      if (bad_ev && (stat_bad_frames != '1))     stat_bad_frames  <= stat_bad_frames + 32'd1;
      if (ovf_ev && (stat_ovf_frames != '1))     stat_ovf_frames  <= stat_ovf_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rx_pkt_fifo.sv
// Directed bench for axis_rx_pkt_fifo (DEPTH=16); also checks counters when AXIS_RX_FIFO_STATS_EN is defined.
module tb_axis_rx_pkt_fifo;
  import axis_eth_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } rx_beat_t;

  logic clk156, rst_n, frame_drop;
  logic tready_cfg, toggle_en, stalled;
  int   checks, passes, drop_count, drop0;
  rx_beat_t rx_q[$], exp_q[$];
  rx_beat_t held;

  axis_rx_pkt_fifo_if s_if();
  axis_rx_pkt_fifo_if m_if();

`ifdef AXIS_RX_FIFO_STATS_EN
  logic [31:0] stat_good_frames, stat_bad_frames, stat_ovf_frames;
`endif

  axis_rx_pkt_fifo #(.DEPTH(DEPTH)) dut (
    .clk156    (clk156),
    .rst_n     (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .frame_drop(frame_drop)
`ifdef AXIS_RX_FIFO_STATS_EN
    ,
    .stat_good_frames(stat_good_frames),
    .stat_bad_frames (stat_bad_frames),
    .stat_ovf_frames (stat_ovf_frames)
`endif
  );

  initial clk156 = 1'b0;
  always #3 clk156 = ~clk156;

  always @(posedge clk156) begin
    #2;
    m_if.tready = toggle_en ? ~m_if.tready : tready_cfg;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Sampled mid-cycle: captures handshakes and enforces AXIS hold while stalled.
  always @(negedge clk156) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled) begin
        checkOutput("stall_data", m_if.tdata, held.data);
        checkOutput("stall_ctl", 64'({m_if.tvalid, m_if.tlast, m_if.tkeep}), 64'({1'b1, held.last, held.keep}));
      end
      if (m_if.tvalid && m_if.tready)
        rx_q.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
      if (frame_drop) drop_count++;
      stalled = m_if.tvalid && !m_if.tready;
      held    = '{m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
    end
  end

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic u);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    @(posedge clk156);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input int n, input logic [63:0] base, input logic [7:0] last_keep,
                           input logic bad, input logic expect_out);
    logic       is_last;
    logic [7:0] k;
    for (int i = 0; i < n; i++) begin
      is_last = (i == n - 1);
      k = is_last ? last_keep : 8'hff;
      applyStimulus(1'b1, base + 64'(i), k, is_last, is_last & bad);
      if (expect_out) exp_q.push_back('{base + 64'(i), k, is_last, 1'b0});
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic drainAndCompare(input string tag, input int budget);
    int n;
    rx_beat_t g, e;
    n = exp_q.size();
    for (int c = 0; c < budget && rx_q.size() < n; c++) @(posedge clk156);
    repeat (8) @(posedge clk156);
    #1;
    checkOutput({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_data"}, g.data, e.data);
      checkOutput({tag, "_ctl"}, 64'({g.user, g.last, g.keep}), 64'({e.user, e.last, e.keep}));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; passes = 0; drop_count = 0;
    rst_n = 1'b0; tready_cfg = 1'b1; toggle_en = 1'b0; stalled = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    checkOutput("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    checkOutput("rst_s_tready", 64'(s_if.tready), 64'd0);
    checkOutput("rst_frame_drop", 64'(frame_drop), 64'd0);
    checkOutput("rst_m_tdata", m_if.tdata, 64'd0);
    checkOutput("rst_m_ctl", 64'({m_if.tuser, m_if.tlast, m_if.tkeep}), 64'd0);

    // Good 5-beat frame, latency from the tlast edge
    rst_n = 1'b1;
    idle(2);
    checkOutput("s_tready_up", 64'(s_if.tready), 64'd1);
    drop0 = drop_count;
    sendFrame(5, 64'h1111_0000_0000_0000, 8'h0f, 1'b0, 1'b1);
    checkOutput("t1_lat_T0", 64'(m_if.tvalid), 64'd0);
    idle(1);
    checkOutput("t1_lat_T1", 64'(m_if.tvalid), 64'd0);
    idle(1);
    checkOutput("t1_lat_T2", 64'(m_if.tvalid), 64'd1);
    checkOutput("t1_first_data", m_if.tdata, 64'h1111_0000_0000_0000);
    drainAndCompare("t1", 50);
    checkOutput("t1_drops", 64'(drop_count - drop0), 64'd0);

    // Bad frame dropped, following good frame passes
    drop0 = drop_count;
    sendFrame(3, 64'h2222_0000_0000_0000, 8'hff, 1'b1, 1'b0);
    checkOutput("t2_drop_pulse", 64'(frame_drop), 64'd1);
    idle(1);
    checkOutput("t2_drop_end", 64'(frame_drop), 64'd0);
    sendFrame(2, 64'h3333_0000_0000_0000, 8'h03, 1'b0, 1'b1);
    drainAndCompare("t2", 50);
    checkOutput("t2_drops", 64'(drop_count - drop0), 64'd1);

    // 20-beat frame overflows a 16-deep buffer with tready low
    tready_cfg = 1'b0;
    idle(2);
    drop0 = drop_count;
    sendFrame(20, 64'h4444_0000_0000_0000, 8'hff, 1'b0, 1'b0);
    checkOutput("t3_drop_pulse", 64'(frame_drop), 64'd1);
    checkOutput("t3_no_out", 64'(m_if.tvalid), 64'd0);
    sendFrame(4, 64'h5555_0000_0000_0000, 8'h01, 1'b0, 1'b1);
    idle(4);
    checkOutput("t3_held_valid", 64'(m_if.tvalid), 64'd1);
    checkOutput("t3_held_data", m_if.tdata, 64'h5555_0000_0000_0000);
    tready_cfg = 1'b1;
    drainAndCompare("t3", 50);
    checkOutput("t3_drops", 64'(drop_count - drop0), 64'd1);

    // Reset released mid-frame: partial frame discarded until its tlast
    rst_n = 1'b0;
    idle(2);
    checkOutput("t4_rst_tready", 64'(s_if.tready), 64'd0);
    checkOutput("t4_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    drop0 = drop_count;
    rst_n = 1'b1;
    applyStimulus(1'b1, 64'h6666_0000_0000_0000, 8'hff, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h6666_0000_0000_0001, 8'hff, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h6666_0000_0000_0002, 8'h0f, 1'b1, 1'b0);
    idle(1);
    sendFrame(3, 64'h7777_0000_0000_0000, 8'h3f, 1'b0, 1'b1);
    drainAndCompare("t4", 50);
    checkOutput("t4_drops", 64'(drop_count - drop0), 64'd0);

    // Back-to-back frames against a toggling tready
    drop0 = drop_count;
    toggle_en = 1'b1;
    sendFrame(8, 64'h8888_0000_0000_0000, 8'h7f, 1'b0, 1'b1);
    sendFrame(8, 64'h9999_0000_0000_0000, 8'hff, 1'b0, 1'b1);
    drainAndCompare("t5", 200);
    toggle_en = 1'b0;
    checkOutput("t5_drops", 64'(drop_count - drop0), 64'd0);

    // Mixed good/bad/overflow traffic after a fresh reset
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    tready_cfg = 1'b0;
    idle(2);
    drop0 = drop_count;
    sendFrame(2, 64'hAAAA_0000_0000_0000, 8'hff, 1'b0, 1'b1);
    sendFrame(3, 64'hBBBB_0000_0000_0000, 8'h1f, 1'b0, 1'b1);
    sendFrame(2, 64'hCCCC_0000_0000_0000, 8'hff, 1'b1, 1'b0);
    sendFrame(18, 64'hDDDD_0000_0000_0000, 8'hff, 1'b0, 1'b0);
    idle(2);
`ifdef AXIS_RX_FIFO_STATS_EN
    checkOutput("stat_good", 64'(stat_good_frames), 64'd2);
    checkOutput("stat_bad", 64'(stat_bad_frames), 64'd1);
    checkOutput("stat_ovf", 64'(stat_ovf_frames), 64'd1);
`endif
    tready_cfg = 1'b1;
    drainAndCompare("t6", 50);
    checkOutput("t6_drops", 64'(drop_count - drop0), 64'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
